// File: rtl/add_seq16.sv
// add_seq16: nibble-serial adder/subtractor.
// One operand pair is accepted over a valid/ready handshake and resolved one
// 4-bit carry-lookahead slice per cycle, LSB first. The carry between nibbles
// lives in a register. The WIDTH-bit result, carry-out and signed overflow are
// then offered over a second valid/ready handshake.
module add_seq16 #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow,
    output logic             busy
);

    localparam int NIB   = WIDTH / 4;
    localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               carry_q, carry_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               cout_q, cout_d;
    logic               ovf_q, ovf_d;

    logic [3:0]         a_nib, b_nib;
    logic [5:0]         slice;
    logic               last_nib;

    // 4-bit carry-lookahead slice; returns {c4, c3, sum[3:0]}.
    // c3 is kept so the caller can form signed overflow on the top nibble.
    function automatic logic [5:0] cla4(input logic [3:0] x,
                                        input logic [3:0] y,
                                        input logic       c0);
        logic [3:0] p;
        logic [3:0] g;
        logic [4:0] c;
        p    = x | y;
        g    = x & y;
        c[0] = c0;
        c[1] = g[0] | (p[0] & c0);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & c0);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & c0);
        return {c[4], c[3], x ^ y ^ c[3:0]};
    endfunction

    // Select the operand nibbles addressed by idx and run them through the slice.
    always_comb begin
        a_nib = 4'h0;
        b_nib = 4'h0;
        for (int n = 0; n < NIB; n++) begin
            if (idx_q == IDX_W'(n)) begin
                a_nib = a_q[4*n +: 4];
                b_nib = b_q[4*n +: 4];
            end
        end
        slice    = cla4(a_nib, b_nib, carry_q);
        last_nib = (idx_q == IDX_W'(NIB - 1));
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: accept in IDLE, walk nibbles in RUN, wait for consumer in DONE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (in_valid)  state_d = S_RUN;
            S_RUN:   if (last_nib)  state_d = S_DONE;
            S_DONE:  if (out_ready) state_d = S_IDLE;
            default:                state_d = S_IDLE;
        endcase
    end

    // Output decode: handshake flags depend only on the state.
    always_comb begin
        in_ready  = (state_q == S_IDLE);
        out_valid = (state_q == S_DONE);
        busy      = (state_q != S_IDLE);
    end

    // Datapath next values: operand capture on accept, one nibble per RUN cycle.
    always_comb begin
        idx_d   = idx_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    // Subtraction is A + ~B + 1 with cin acting as borrow-in.
                    a_d     = a;
                    b_d     = sub ? ~b : b;
                    carry_d = cin ^ sub;
                    idx_d   = '0;
                end
            end
            S_RUN: begin
                for (int n = 0; n < NIB; n++) begin
                    if (idx_q == IDX_W'(n)) begin
                        sum_d[4*n +: 4] = slice[3:0];
                    end
                end
                carry_d = slice[5];
                if (last_nib) begin
                    cout_d = slice[5];
                    ovf_d  = slice[5] ^ slice[4];
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Control and result registers; cleared by reset so an aborted op leaves no result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q   <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            idx_q   <= idx_d;
            carry_q <= carry_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    // Operand holding registers; only read in RUN after a capture, so no reset needed.
    always_ff @(posedge clk) begin
        a_q <= a_d;
        b_q <= b_d;
    end

    assign sum      = sum_q;
    assign cout     = cout_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_add_seq16.sv
// Directed bench for add_seq16 (WIDTH=16): latency, arithmetic corner cases,
// backpressure, reset abort and back-to-back streaming.
module tb_add_seq16;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] sum;
    logic        cout;
    logic        overflow;
    logic        busy;

    int checks = 0;
    int errors = 0;

    add_seq16 #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .overflow  (overflow),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full operation with out_ready high: checks exact 4-cycle latency and result.
    task automatic do_op(input string tag, input logic [15:0] ia, input logic [15:0] ib,
                         input logic ic, input logic is,
                         input logic [15:0] es, input logic ec, input logic eo);
        a = ia; b = ib; cin = ic; sub = is; in_valid = 1'b1; out_ready = 1'b1;
        chk({tag, "_in_ready"}, in_ready, 1);
        tick();
        in_valid = 1'b0;
        chk({tag, "_busy"}, busy, 1);
        for (int k = 1; k <= 3; k++) begin
            tick();
            chk({tag, "_early_valid"}, out_valid, 0);
        end
        tick();
        chk({tag, "_out_valid"}, out_valid, 1);
        chk({tag, "_sum"}, sum, es);
        chk({tag, "_cout"}, cout, ec);
        chk({tag, "_ovf"}, overflow, eo);
        tick();
        chk({tag, "_idle"}, in_ready, 1);
    endtask

    logic [15:0] bs_a [3];
    logic [15:0] bs_b [3];
    logic        bs_c [3];
    logic        bs_s [3];
    logic [15:0] bs_e [3];
    logic        bs_co[3];

    initial begin
        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        out_ready = 1'b1;

        // Reset state
        tick();
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_sum", sum, 16'h0000);
        chk("rst_cout", cout, 0);
        chk("rst_ovf", overflow, 0);
        tick();
        rst = 1'b0;
        tick();

        // Arithmetic cases
        do_op("add",    16'h1234, 16'h0FCD, 1'b0, 1'b0, 16'h2201, 1'b0, 1'b0);
        do_op("ripple", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        do_op("posovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        do_op("sub5_7", 16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        do_op("subovf", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);

        // Reset mid-RUN after two nibbles (previous result has cout=1, overflow=1)
        a = 16'h1234; b = 16'h1111; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        chk("mid_partial_sum", sum[7:0], 8'h45);
        rst = 1'b1;
        #1;
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_sum", sum, 16'h0000);
        chk("mid_rst_cout", cout, 0);
        chk("mid_rst_ovf", overflow, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_in_ready", in_ready, 1);
        tick();
        rst = 1'b0;
        do_op("after_rst", 16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0);

        do_op("borrowin", 16'h0010, 16'h0001, 1'b1, 1'b1, 16'h000E, 1'b1, 1'b0);

        // Backpressure: hold DONE with in_valid high and changing operands
        a = 16'h00FF; b = 16'h0001; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
        out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        chk("bp_valid", out_valid, 1);
        in_valid = 1'b1;
        for (int k = 0; k < 10; k++) begin
            a = 16'h1000 + 16'(k * 16'h0111);
            b = 16'hF00F - 16'(k);
            tick();
            chk("bp_hold_valid", out_valid, 1);
            chk("bp_hold_ready", in_ready, 0);
            chk("bp_hold_sum", sum, 16'h0100);
            chk("bp_hold_cout", cout, 0);
            chk("bp_hold_ovf", overflow, 0);
        end
        a = 16'h1111; b = 16'h2222; cin = 1'b0; sub = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("bp_release_idle", in_ready, 1);
        chk("bp_release_busy", busy, 0);
        tick();
        chk("bp_pending_accept", busy, 1);
        in_valid = 1'b0;
        for (int k = 0; k < 3; k++) tick();
        chk("bp_pending_early", out_valid, 0);
        tick();
        chk("bp_pending_valid", out_valid, 1);
        chk("bp_pending_sum", sum, 16'h3333);
        chk("bp_pending_cout", cout, 0);
        tick();

        // Back-to-back stream with in_valid held high
        bs_a[0] = 16'h0001; bs_b[0] = 16'h0002; bs_c[0] = 1'b1; bs_s[0] = 1'b0; bs_e[0] = 16'h0004; bs_co[0] = 1'b0;
        bs_a[1] = 16'h00F0; bs_b[1] = 16'h0010; bs_c[1] = 1'b0; bs_s[1] = 1'b1; bs_e[1] = 16'h00E0; bs_co[1] = 1'b1;
        bs_a[2] = 16'hABCD; bs_b[2] = 16'h1111; bs_c[2] = 1'b1; bs_s[2] = 1'b0; bs_e[2] = 16'hBCDF; bs_co[2] = 1'b0;
        out_ready = 1'b1;
        a = bs_a[0]; b = bs_b[0]; cin = bs_c[0]; sub = bs_s[0]; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("b2b_ready", in_ready, 1);
            tick();
            chk("b2b_accept", busy, 1);
            if (i < 2) begin
                a = bs_a[i+1]; b = bs_b[i+1]; cin = bs_c[i+1]; sub = bs_s[i+1];
            end else begin
                in_valid = 1'b0;
            end
            for (int k = 0; k < 3; k++) tick();
            chk("b2b_early", out_valid, 0);
            tick();
            chk("b2b_valid", out_valid, 1);
            chk("b2b_sum", sum, bs_e[i]);
            chk("b2b_cout", cout, bs_co[i]);
            tick();
            chk("b2b_gap_idle", busy, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
